instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter MAX_OUTST, default 2: maximum of buffered plus in-flight fetches, fixed at 2.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-004 Port list:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, word-aligned.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; responses return in order.
- imem_rdata  input  32  instruction word.
- redirect  input  1  branch/jump taken; flush.
- redirect_pc  input  32  new fetch address.
- stall  input  1  decode cannot accept this cycle.
- instr_valid  output  1  instruction presented; drives the controller SS2 enable.
- instr  output  32  instruction word.
- pc  output  32  address of instr.
- op  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7b5  output  1  instr[30].
- funct7b1  output  1  instr[26].

Function
REQ-005 SHALL assert imem_req whenever buffer occupancy plus outstanding grants is < 2 and no redirect is present this cycle.
REQ-006 SHALL hold imem_addr stable while imem_req=1 and imem_gnt=0.
REQ-007 SHALL advance the fetch PC by 4 on each grant, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-008 SHALL write each imem_rvalid word, with its address, into a 2-entry in-order buffer.
REQ-009 SHALL drive instr_valid=1 whenever the buffer is non-empty.
REQ-010 SHALL pop the buffer head when instr_valid=1 and stall=0.
REQ-011 SHALL make op/funct3/funct7b5/funct7b1 combinational slices of instr.
REQ-012 SHALL force instr, pc and all field outputs to 0 when instr_valid=0.
REQ-013 SHALL allow a push and a pop in the same cycle with occupancy unchanged.
REQ-014 SHALL never let the buffer overflow, guaranteed by the REQ-005 credit rule; no imem_rvalid is ever dropped except under REQ-015.
REQ-015 Redirect, in the same cycle:
- empty the buffer;
- instr_valid=0 next cycle;
- set the fetch PC to {redirect_pc[31:2],2'b00};
- load a discard counter with all outstanding grants, including any grant in the redirect cycle;
- drop the next that-many imem_rvalid responses.
REQ-016 SHALL deassert imem_req during the redirect cycle and reissue at the new PC the next cycle, if credit allows.
REQ-017 SHALL give redirect priority over stall, push and pop.
REQ-018 SHALL ignore imem_rvalid arriving with no outstanding grant.

Reset
REQ-019 While rst_n=0:
- imem_req=0, imem_addr=RESET_PC;
- instr_valid=0; instr, pc and all field outputs 0;
- buffer empty; outstanding and discard counters 0.
REQ-020 SHALL allow imem_req=1 no earlier than the first rising edge after rst_n deasserts.
REQ-021 SHALL make reset asserted mid-transaction abandon all in-flight fetches without waiting for responses.

Configuration
REQ-022 Macro FETCH_PERF_EN:
- when defined, add output perf_issued (32 bits), reset 0, +1 per pop (REQ-010), wrapping at 2^32, unaffected by redirect;
- when undefined, the port and counter are absent and all other behaviour is identical.

Structure
REQ-023 Package fetch_pkg SHALL hold:
- RESET_PC default;
- buffer depth constant 2;
- field bit-position localparams;
- the buffer-entry struct {addr[31:0], data[31:0]}.
REQ-024 The 2-entry buffer SHALL be sub-module fetch_fifo, with push, pop, full and empty signals and simultaneous push/pop support.

Verification
REQ-025 Reset release, imem_gnt tied 1, imem_rvalid one cycle after grant -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid=1 from cycle 3; op matches imem_rdata[6:0].
REQ-026 stall=1 for 5 cycles with 2 entries buffered -> imem_req=0 and instr/pc held; after stall=0, one pop per cycle in address order.
REQ-027 redirect=1 with redirect_pc=32'h0000_0103 and 2 grants outstanding -> next 2 imem_rvalid discarded; next imem_addr=32'h100; first instr_valid shows pc=32'h100.
REQ-028 Fetch PC at 32'hFFFF_FFFC, one grant -> next imem_addr=32'h0000_0000.
REQ-029 rst_n pulsed low mid-fetch with 1 outstanding -> outputs immediately at reset values; late imem_rvalid ignored; first post-reset address RESET_PC.
REQ-030 With FETCH_PERF_EN defined, 10 pops with one redirect in between -> perf_issued=10.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch unit
//
// Purpose: reset address default, buffer depth, instruction field bit positions
//          and the buffered entry type used by instr_fetch and fetch_fifo.
// Ports:   none (package).

package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          FIFO_DEPTH       = 2;

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 6;
    localparam int F3_LSB   = 12;
    localparam int F3_MSB   = 14;
    localparam int F7B5_BIT = 30;
    localparam int F7B1_BIT = 26;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry in-order buffer of fetched (address, word) pairs
//
// Purpose: holds returned instructions until decode accepts them; push and pop
//          may happen in the same cycle, flush empties it at once.
// Ports:   clk, rst_n        clock, asynchronous active-low reset
//          flush_i           discard all entries (wins over push/pop)
//          push_i, wr_entry_i write an entry at the tail
//          pop_i             remove the head entry
//          rd_entry_o        head entry (valid when !empty_o)
//          full_o, empty_o   occupancy flags
//          count_o           current occupancy 0..2

module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t wr_entry_i,
    input  logic         pop_i,
    output fetch_entry_t rd_entry_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [FIFO_DEPTH];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A full buffer can still take a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != 2'(FIFO_DEPTH)) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= wr_entry_i;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_entry_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == 2'(FIFO_DEPTH));
    assign empty_o    = (count_q == 2'd0);
    assign count_o    = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - credit-limited in-order instruction fetch with redirect flush
//
// Purpose: issues word fetches to instruction memory, buffers up to two returned
//          words, presents them to decode with pre-sliced opcode fields, and
//          flushes on redirect while discarding responses already in flight.
// Ports:   clk, rst_n                        clock, asynchronous active-low reset
//          imem_req/imem_addr/imem_gnt       request channel (addr held until grant)
//          imem_rvalid/imem_rdata            in-order response channel
//          redirect/redirect_pc              taken branch/jump, new fetch target
//          stall                             decode not ready
//          instr_valid/instr/pc              presented instruction (zero when invalid)
//          op/funct3/funct7b5/funct7b1       fields of instr
//          perf_issued                       pop counter, only with FETCH_PERF_EN
// Config:  FETCH_PERF_EN adds the perf_issued output and its counter.

module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        funct7b1
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_issued
`endif
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic         run_q;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  resp_pc_q, resp_pc_d;
    logic [1:0]   outst_q, outst_d;
    logic [1:0]   disc_q, disc_d;
    logic [1:0]   occ;
    logic [2:0]   credit_used;
    logic         fifo_full, fifo_empty;
    fetch_entry_t head, wr_entry;
    logic         gnt_acc, rsp_acc, rsp_keep, push, pop;
    logic [31:0]  target_pc;

    // run_q keeps imem_req low until the first rising edge after reset release.
    assign credit_used = {1'b0, occ} + {1'b0, outst_q};
    assign imem_req    = run_q && !redirect && (credit_used < 3'(MAX_OUTST));
    assign imem_addr   = fetch_pc_q;
    assign gnt_acc     = imem_req && imem_gnt;

    // Responses with nothing outstanding are stray and ignored.
    assign rsp_acc     = imem_rvalid && (outst_q != 2'd0);
    assign rsp_keep    = rsp_acc && (disc_q == 2'd0);

    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && !stall && !redirect;
    assign push        = rsp_keep && !redirect && (!fifo_full || pop);
    assign target_pc   = redirect_pc & ALIGN_MASK;

    // Responses return in order and consecutively, so the address of the next
    // kept response is tracked instead of queuing addresses per grant.
    assign wr_entry    = '{addr: resp_pc_q, data: imem_rdata};

    always_comb begin
        outst_d    = outst_q + {1'b0, gnt_acc} - {1'b0, rsp_acc};
        disc_d     = disc_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (rsp_acc && (disc_q != 2'd0)) disc_d = disc_q - 2'd1;
        if (gnt_acc) fetch_pc_d = fetch_pc_q + 32'd4;
        if (push)    resp_pc_d  = resp_pc_q + 32'd4;
        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            disc_d     = outst_d;
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC & ALIGN_MASK;
            resp_pc_q  <= RESET_PC & ALIGN_MASK;
            outst_q    <= 2'd0;
            disc_q     <= 2'd0;
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            disc_q     <= disc_d;
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect),
        .push_i     (push),
        .wr_entry_i (wr_entry),
        .pop_i      (pop),
        .rd_entry_o (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (occ)
    );

    assign instr    = instr_valid ? head.data : 32'd0;
    assign pc       = instr_valid ? head.addr : 32'd0;
    assign op       = instr[OP_MSB:OP_LSB];
    assign funct3   = instr[F3_MSB:F3_LSB];
    assign funct7b5 = instr[F7B5_BIT];
    assign funct7b1 = instr[F7B1_BIT];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 32'd0;
        end else if (pop) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_issued = perf_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with memory and stream model

module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        funct7b1;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_issued;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC), .MAX_OUTST(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .funct7b1    (funct7b1)
`ifdef FETCH_PERF_EN
        ,
        .perf_issued (perf_issued)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // stimulus controls
    logic        tb_rst_n = 1'b0;
    logic        tb_stall = 1'b0;
    logic        tb_redirect = 1'b0;
    logic [31:0] tb_rpc = 32'd0;
    bit          tb_spurious = 1'b0;
    int unsigned gnt_pct = 0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;

    // memory model: granted addresses waiting to be answered, in order
    logic [31:0] q_addr[$];
    int          q_due[$];

    // per-cycle samples
    logic        s_req, s_valid, s_rv, s_f5, s_f1;
    logic [31:0] s_addr, s_instr, s_pc;
    logic [6:0]  s_op;
    logic [2:0]  s_f3;
    bit          granted, popped;

    // reference stream model: next fetch address, next delivered pc
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] e_fetch, e_pc;
    int          n_pops = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1 ^ (a * 32'h9E37_79B1);
    endfunction

    task automatic cycle();
        @(negedge clk);
        cyc++;
        rst_n       = tb_rst_n;
        stall       = tb_stall;
        redirect    = tb_redirect;
        redirect_pc = tb_rpc;
        imem_gnt    = ($urandom_range(99, 0) < gnt_pct);
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else if (tb_spurious) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_rv = imem_rvalid;
        s_instr = instr; s_pc = pc; s_op = op; s_f3 = funct3; s_f5 = funct7b5; s_f1 = funct7b1;
        granted = s_req && imem_gnt;
        popped  = s_valid && !tb_stall && !tb_redirect;
        e_fetch = exp_fetch;
        e_pc    = exp_pc;
        if (!tb_rst_n) begin
            exp_fetch = RST_PC;
            exp_pc    = RST_PC;
            n_pops    = 0;
        end else if (tb_redirect) begin
            exp_fetch = tb_rpc & 32'hFFFF_FFFC;
            exp_pc    = tb_rpc & 32'hFFFF_FFFC;
        end else begin
            if (granted) begin
                q_addr.push_back(s_addr);
                q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                exp_fetch = exp_fetch + 32'd4;
            end
            if (popped) begin
                exp_pc = exp_pc + 32'd4;
                n_pops++;
            end
        end
    endtask

    task automatic drain(output bit ok);
        gnt_pct = 0; tb_stall = 1'b0; tb_redirect = 1'b0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (q_addr.size() == 0 && !s_valid && !s_rv) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tb_rst_n = 1'b0; rst_n = 1'b0;
        cycle(); cycle();
        n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", s_req); end
        n_cmp++; if (s_addr !== RST_PC) begin n_fail++; $display("FAIL rst_addr: got %h want %h", s_addr, RST_PC); end
        n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", s_valid); end
        n_cmp++;
        if (s_instr !== 32'd0 || s_pc !== 32'd0 || {s_op, s_f3, s_f5, s_f1} !== 12'd0) begin
            n_fail++; $display("FAIL rst_outputs: instr %h pc %h fields %h want all 0", s_instr, s_pc, {s_op, s_f3, s_f5, s_f1});
        end
        tb_rst_n = 1'b1;
        cycle();
        n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL req_before_edge: got %b want 0", s_req); end
    endtask

    task automatic test_basic();
        logic [31:0] gaddr[$];
        logic [31:0] w;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        w = mem_word(RST_PC);
        for (int i = 1; i <= 9; i++) begin
            cycle();
            if (granted) gaddr.push_back(s_addr);
            if (i <= 2) begin
                n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_c%0d: got %b want 0", i, s_valid); end
            end
            if (i == 3) begin
                n_cmp++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_c3: got %b want 1", s_valid); end
                n_cmp++; if (s_pc !== RST_PC) begin n_fail++; $display("FAIL basic_pc_c3: got %h want %h", s_pc, RST_PC); end
                n_cmp++; if (s_op !== w[6:0]) begin n_fail++; $display("FAIL basic_op_c3: got %h want %h", s_op, w[6:0]); end
            end
        end
        n_cmp++;
        if (gaddr.size() < 3) begin
            n_fail++; $display("FAIL basic_grants: got %0d grants want >=3", gaddr.size());
        end else if (gaddr[0] !== 32'h0 || gaddr[1] !== 32'h4 || gaddr[2] !== 32'h8) begin
            n_fail++; $display("FAIL basic_addr_seq: got %h %h %h want 0 4 8", gaddr[0], gaddr[1], gaddr[2]);
        end
    endtask

    task automatic test_stall();
        gnt_pct = 100; lat_min = 1; lat_max = 1; tb_stall = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_%0d: got %b want 0", i, s_req); end
            n_cmp++;
            if (s_valid !== 1'b1 || s_pc !== e_pc || s_instr !== mem_word(e_pc)) begin
                n_fail++; $display("FAIL stall_hold_%0d: valid %b pc %h instr %h want 1 %h %h", i, s_valid, s_pc, s_instr, e_pc, mem_word(e_pc));
            end
        end
        tb_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (s_valid !== 1'b1 || s_pc !== e_pc || s_instr !== mem_word(e_pc)) begin
                n_fail++; $display("FAIL stall_release_pop_%0d: valid %b pc %h instr %h want 1 %h %h", i, s_valid, s_pc, s_instr, e_pc, mem_word(e_pc));
            end
        end
    endtask

    task automatic test_redirect();
        bit ok, seen_g, seen_v;
        drain(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL redir_drain: got busy want idle"); end
        gnt_pct = 100; lat_min = 6; lat_max = 6;
        cycle(); cycle();
        n_cmp++; if (q_addr.size() != 2) begin n_fail++; $display("FAIL redir_outstanding: got %0d want 2", q_addr.size()); end
        tb_redirect = 1'b1; tb_rpc = 32'h0000_0103;
        cycle();
        n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b want 0", s_req); end
        tb_redirect = 1'b0; lat_min = 1; lat_max = 1;
        seen_g = 0; seen_v = 0;
        for (int i = 0; i < 30 && !(seen_g && seen_v); i++) begin
            cycle();
            if (granted && !seen_g) begin
                seen_g = 1;
                n_cmp++; if (s_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %h want 00000100", s_addr); end
            end
            if (s_valid && !seen_v) begin
                seen_v = 1;
                n_cmp++;
                if (s_pc !== 32'h100 || s_instr !== mem_word(32'h100)) begin
                    n_fail++; $display("FAIL redir_first_instr: pc %h instr %h want 00000100 %h", s_pc, s_instr, mem_word(32'h100));
                end
            end
        end
        n_cmp++; if (!(seen_g && seen_v)) begin n_fail++; $display("FAIL redir_timeout: grant %b valid %b want 1 1", seen_g, seen_v); end
    endtask

    task automatic test_wrap();
        logic [31:0] ga[$];
        logic [31:0] pa[$];
        logic [31:0] ia[$];
        gnt_pct = 100; lat_min = 1; lat_max = 1; tb_stall = 1'b0;
        tb_redirect = 1'b1; tb_rpc = 32'hFFFF_FFFE;
        cycle();
        tb_redirect = 1'b0;
        for (int i = 0; i < 30 && (ga.size() < 2 || pa.size() < 2); i++) begin
            cycle();
            if (granted) ga.push_back(s_addr);
            if (s_valid) begin pa.push_back(s_pc); ia.push_back(s_instr); end
        end
        n_cmp++;
        if (ga.size() < 2 || ga[0] !== 32'hFFFF_FFFC || ga[1] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addr: got %0d grants first %h want FFFFFFFC then 00000000", ga.size(), (ga.size() > 0) ? ga[0] : 32'hX);
        end
        n_cmp++;
        if (pa.size() < 2 || pa[0] !== 32'hFFFF_FFFC || pa[1] !== 32'h0 ||
            ia[0] !== mem_word(32'hFFFF_FFFC) || ia[1] !== mem_word(32'h0)) begin
            n_fail++; $display("FAIL wrap_stream: got %0d instrs first pc %h want FFFFFFFC then 00000000", pa.size(), (pa.size() > 0) ? pa[0] : 32'hX);
        end
    endtask

    task automatic test_spurious();
        bit ok, seen_v;
        drain(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL spur_drain: got busy want idle"); end
        tb_spurious = 1'b1;
        cycle();
        tb_spurious = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL spur_valid_%0d: got %b want 0", i, s_valid); end
        end
        gnt_pct = 100; lat_min = 1; lat_max = 1; seen_v = 0;
        for (int i = 0; i < 20 && !seen_v; i++) begin
            cycle();
            if (s_valid) begin
                seen_v = 1;
                n_cmp++;
                if (s_pc !== e_pc || s_instr !== mem_word(e_pc)) begin
                    n_fail++; $display("FAIL spur_next_instr: pc %h instr %h want %h %h", s_pc, s_instr, e_pc, mem_word(e_pc));
                end
            end
        end
        n_cmp++; if (!seen_v) begin n_fail++; $display("FAIL spur_timeout: got no instr want one"); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen_g, seen_v;
        drain(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_drain: got busy want idle"); end
        gnt_pct = 100; lat_min = 4; lat_max = 4;
        cycle();
        n_cmp++; if (!granted) begin n_fail++; $display("FAIL rmid_grant: got %b want 1", granted); end
        gnt_pct = 0;
        cycle();
        #2;
        rst_n = 1'b0; tb_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || instr_valid !== 1'b0 || instr !== 32'd0 || pc !== 32'd0) begin
            n_fail++; $display("FAIL rmid_async: req %b addr %h valid %b instr %h pc %h want 0 %h 0 0 0", imem_req, imem_addr, instr_valid, instr, pc, RST_PC);
        end
        cycle(); cycle();
        tb_rst_n = 1'b1;
        cycle();
        n_cmp++; if (s_rv !== 1'b1) begin n_fail++; $display("FAIL rmid_late_rvalid: got %b want 1", s_rv); end
        gnt_pct = 100; lat_min = 1; lat_max = 1; seen_g = 0; seen_v = 0;
        for (int i = 0; i < 20 && !(seen_g && seen_v); i++) begin
            cycle();
            if (granted && !seen_g) begin
                seen_g = 1;
                n_cmp++; if (s_addr !== RST_PC) begin n_fail++; $display("FAIL rmid_first_addr: got %h want %h", s_addr, RST_PC); end
            end
            if (s_valid && !seen_v) begin
                seen_v = 1;
                n_cmp++;
                if (s_pc !== RST_PC || s_instr !== mem_word(RST_PC)) begin
                    n_fail++; $display("FAIL rmid_first_instr: pc %h instr %h want %h %h", s_pc, s_instr, RST_PC, mem_word(RST_PC));
                end
            end
        end
        n_cmp++; if (!(seen_g && seen_v)) begin n_fail++; $display("FAIL rmid_timeout: grant %b valid %b want 1 1", seen_g, seen_v); end
    endtask

    task automatic test_random();
        bit          prev_hold;
        logic [31:0] prev_addr, w;
        int          pops0;
        pops0 = n_pops; prev_hold = 0; prev_addr = 32'd0;
        gnt_pct = 70; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            tb_stall    = ($urandom_range(99, 0) < 25);
            tb_redirect = ($urandom_range(99, 0) < 4);
            tb_rpc      = ($urandom_range(3, 0) == 0) ? $urandom : $urandom_range(32'h3FF, 0);
            cycle();
            if (tb_redirect) begin
                n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_req @%0d: got %b want 0", cyc, s_req); end
            end
            if (prev_hold && !tb_redirect) begin
                n_cmp++;
                if (s_req !== 1'b1 || s_addr !== prev_addr) begin
                    n_fail++; $display("FAIL rnd_addr_hold @%0d: req %b addr %h want 1 %h", cyc, s_req, s_addr, prev_addr);
                end
            end
            if (granted && !tb_redirect) begin
                n_cmp++; if (s_addr !== e_fetch) begin n_fail++; $display("FAIL rnd_fetch_addr @%0d: got %h want %h", cyc, s_addr, e_fetch); end
            end
            if (s_valid) begin
                w = mem_word(e_pc);
                n_cmp++;
                if (s_pc !== e_pc || s_instr !== w) begin
                    n_fail++; $display("FAIL rnd_instr @%0d: pc %h instr %h want %h %h", cyc, s_pc, s_instr, e_pc, w);
                end
                n_cmp++;
                if (s_op !== w[6:0] || s_f3 !== w[14:12] || s_f5 !== w[30] || s_f1 !== w[26]) begin
                    n_fail++; $display("FAIL rnd_fields @%0d: got %h %h %b %b want %h %h %b %b", cyc, s_op, s_f3, s_f5, s_f1, w[6:0], w[14:12], w[30], w[26]);
                end
            end else begin
                n_cmp++;
                if (s_instr !== 32'd0 || s_pc !== 32'd0 || {s_op, s_f3, s_f5, s_f1} !== 12'd0) begin
                    n_fail++; $display("FAIL rnd_idle_zero @%0d: instr %h pc %h want 0 0", cyc, s_instr, s_pc);
                end
            end
            n_cmp++; if (q_addr.size() > 2) begin n_fail++; $display("FAIL rnd_credit @%0d: got %0d in flight want <=2", cyc, q_addr.size()); end
            prev_hold = s_req && !imem_gnt;
            prev_addr = s_addr;
        end
        tb_stall = 1'b0; tb_redirect = 1'b0;
        n_cmp++; if (n_pops - pops0 < 60) begin n_fail++; $display("FAIL rnd_progress: got %0d pops want >=60", n_pops - pops0); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        tb_stall = 1'b1;
        cycle();
        n_cmp++;
        if (perf_issued !== 32'(n_pops)) begin
            n_fail++; $display("FAIL perf_issued: got %0d want %0d", perf_issued, n_pops);
        end
        tb_stall = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_spurious();
        test_reset_mid();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
